// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module : ctrl_pkg
// Brief  : Shared encodings for the multicycle MIPS controller and its monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  // alucontrol sits in the low bits so it can be masked off as a group
  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_vec_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == c_OP_LW) || (op == c_OP_SW) || (op == c_OP_RTYPE) ||
           (op == c_OP_BEQ) || (op == c_OP_ADDI) || (op == c_OP_J);
  endfunction

  function automatic logic is_terminal(input state_t s);
    return s inside {MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX};
  endfunction

  // {valid, alucontrol} for an R-type funct field
  function automatic logic [3:0] alu_decode(input logic [5:0] funct);
    case (funct)
      c_FN_ADD: return {1'b1, c_ALU_ADD};
      c_FN_SUB: return {1'b1, c_ALU_SUB};
      c_FN_AND: return {1'b1, c_ALU_AND};
      c_FN_OR:  return {1'b1, c_ALU_OR};
      c_FN_SLT: return {1'b1, c_ALU_SLT};
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] op_q);
    case (s)
      FETCH:   return DECODE;
      DECODE: begin
        case (op)
          c_OP_LW, c_OP_SW: return MEMADR;
          c_OP_RTYPE:       return RTYPEEX;
          c_OP_BEQ:         return BEQEX;
          c_OP_ADDI:        return ADDIEX;
          c_OP_J:           return JEX;
          default:          return FETCH;
        endcase
      end
      MEMADR:  return (op_q == c_OP_SW) ? MEMWR : MEMRD;
      MEMRD:   return MEMWB;
      RTYPEEX: return RTYPEWB;
      ADDIEX:  return ADDIWB;
      default: return FETCH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_sig_match.sv
// ============================================================================
// Module : ctrl_sig_match
// Brief  : Compares a control vector against the signature of a given state.
//          ALU_CHECK_EN adds alucontrol (and R-type funct) to the signature.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_sig_match
  import ctrl_pkg::*;
(
  input  state_t     exp_i,
  input  logic [5:0] op_q_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  ctrl_vec_t  vec_i,
  output logic       match_o
);

  ctrl_vec_t   w_sig;
  logic        w_legal;
  logic [2:0]  w_alu_mask;
  logic [3:0]  w_fn;
  logic [14:0] w_mask;

`ifdef ALU_CHECK_EN
  assign w_alu_mask = 3'b111;
  assign w_fn       = alu_decode(funct_i);
`else
  logic w_unused_funct;
  assign w_unused_funct = ^funct_i;
  assign w_alu_mask     = 3'b000;
  assign w_fn           = {1'b1, c_ALU_ADD};
`endif

  assign w_mask = {12'hFFF, w_alu_mask};

  always_comb begin
    w_sig   = '0;
    w_legal = 1'b1;
    case (exp_i)
      FETCH: begin
        w_sig.pcen       = 1'b1;
        w_sig.irwrite    = 1'b1;
        w_sig.alusrcb    = 2'b01;
        w_sig.alucontrol = c_ALU_ADD;
      end
      DECODE: begin
        w_sig.alusrcb    = 2'b11;
        w_sig.alucontrol = c_ALU_ADD;
      end
      // MEMADR and ADDIEX look identical on the bus; op_q tells them apart
      MEMADR, ADDIEX: begin
        w_sig.alusrca    = 1'b1;
        w_sig.alusrcb    = 2'b10;
        w_sig.alucontrol = c_ALU_ADD;
        w_legal = (exp_i == ADDIEX) ? (op_q_i == c_OP_ADDI)
                                    : (op_q_i == c_OP_LW || op_q_i == c_OP_SW);
      end
      MEMRD:   w_sig.iord = 1'b1;
      MEMWB: begin
        w_sig.regwrite = 1'b1;
        w_sig.memtoreg = 1'b1;
      end
      MEMWR: begin
        w_sig.iord     = 1'b1;
        w_sig.memwrite = 1'b1;
      end
      RTYPEEX: begin
        w_sig.alusrca    = 1'b1;
        w_sig.alucontrol = w_fn[2:0];
        w_legal          = w_fn[3];
      end
      RTYPEWB: begin
        w_sig.regwrite = 1'b1;
        w_sig.regdst   = 1'b1;
      end
      BEQEX: begin
        w_sig.alusrca    = 1'b1;
        w_sig.pcsrc      = 2'b01;
        w_sig.pcen       = zero_i;
        w_sig.alucontrol = c_ALU_SUB;
      end
      ADDIWB:  w_sig.regwrite = 1'b1;
      JEX: begin
        w_sig.pcen  = 1'b1;
        w_sig.pcsrc = 2'b10;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign match_o = w_legal && (((vec_i ^ w_sig) & w_mask) == 15'd0);

endmodule

`default_nettype wire

// File: rtl/ctrl_monitor.sv
// ============================================================================
// Module : ctrl_monitor
// Brief  : Passive checker of the controller bus; tracks the expected state,
//          counts retired instructions/cycles, flags illegal vectors.
//          Optional macro ALU_CHECK_EN also checks alucontrol.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_monitor
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             pcen,
  input  logic             memwrite,
  input  logic             irwrite,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic             iord,
  input  logic             memtoreg,
  input  logic             regdst,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err,
  output logic [3:0]       err_state,
  output logic             lost
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  ctrl_vec_t        w_vec;
  logic             w_match;
  logic             w_fetch_match;
  logic             w_bad;

  state_t           exp_q, exp_d;
  state_t           state_q, state_d;
  state_t           err_state_q, err_state_d;
  logic [5:0]       op_q, op_d;
  logic             lost_q, lost_d;
  logic             retire_q, retire_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  assign w_vec = '{pcen: pcen, memwrite: memwrite, irwrite: irwrite,
                   regwrite: regwrite, alusrca: alusrca, iord: iord,
                   memtoreg: memtoreg, regdst: regdst, alusrcb: alusrcb,
                   pcsrc: pcsrc, alucontrol: alucontrol};

  ctrl_sig_match u_match (
    .exp_i   (exp_q),
    .op_q_i  (op_q),
    .funct_i (funct),
    .zero_i  (zero),
    .vec_i   (w_vec),
    .match_o (w_match)
  );

  ctrl_sig_match u_fetch_match (
    .exp_i   (FETCH),
    .op_q_i  (op_q),
    .funct_i (funct),
    .zero_i  (zero),
    .vec_i   (w_vec),
    .match_o (w_fetch_match)
  );

  assign w_bad = !lost_q && (!w_match || (exp_q == DECODE && !op_known(op)));

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q       <= FETCH;
      state_q     <= FETCH;
      err_state_q <= FETCH;
      op_q        <= '0;
      lost_q      <= 1'b0;
      retire_q    <= 1'b0;
      err_q       <= 1'b0;
      icnt_q      <= '0;
      ccnt_q      <= '0;
    end else begin
      exp_q       <= exp_d;
      state_q     <= state_d;
      err_state_q <= err_state_d;
      op_q        <= op_d;
      lost_q      <= lost_d;
      retire_q    <= retire_d;
      err_q       <= err_d;
      icnt_q      <= icnt_d;
      ccnt_q      <= ccnt_d;
    end
  end

  // Expected-state successor; a lost monitor waits for a FETCH vector
  always_comb begin
    exp_d  = exp_q;
    op_d   = op_q;
    lost_d = lost_q;
    if (lost_q) begin
      if (w_fetch_match) begin
        lost_d = 1'b0;
        exp_d  = DECODE;
      end
    end else if (w_bad) begin
      lost_d = 1'b1;
    end else begin
      exp_d = next_state(exp_q, op, op_q);
      if (exp_q == DECODE) op_d = op;
    end
  end

  always_comb begin
    state_d = state_q;
    if (lost_q && w_fetch_match) state_d = FETCH;
    else if (!lost_q && !w_bad)  state_d = exp_q;

    retire_d    = !lost_q && !w_bad && is_terminal(exp_q);
    icnt_d      = (retire_d && icnt_q != c_CNT_MAX) ? icnt_q + c_CNT_ONE : icnt_q;
    ccnt_d      = (ccnt_q != c_CNT_MAX) ? ccnt_q + c_CNT_ONE : ccnt_q;
    err_d       = err_q | w_bad;
    err_state_d = (w_bad && !err_q) ? exp_q : err_state_q;
  end

  assign state       = state_q;
  assign retire      = retire_q;
  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
  assign err         = err_q;
  assign err_state   = err_state_q;
  assign lost        = lost_q;

endmodule

`default_nettype wire

// File: doc/ctrl_monitor.md
Name: ctrl_monitor

Overview:
- Passive observer on the multicycle MIPS controller-to-datapath control bus; the receiving end of the interface the `controller` drives.
- Decodes each cycle's control vector back into a controller FSM state, checks it is a legal successor given the latched opcode, and pulses `retire` when an instruction completes.
- Counts retired instructions and cycles; raises a sticky error on any illegal vector.
- Instantiated beside `controller` in the top level and in benches; drives no datapath signals.

Parameters:
- CNT_W, 16, width of `instr_count` and `cycle_count`; both counters saturate at all-ones.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instruction opcode (IR[31:26])
- funct  in  6  instruction funct field (IR[5:0])
- zero  in  1  ALU zero flag
- pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst  in  1 each  controller outputs
- alusrcb  in  2  controller output
- pcsrc  in  2  controller output
- alucontrol  in  3  controller output
- state  out  4  decoded current state (package encoding)
- retire  out  1  one-cycle pulse on the final cycle of an instruction
- instr_count  out  CNT_W  retired instructions
- cycle_count  out  CNT_W  cycles since reset
- err  out  1  sticky illegal-vector flag
- err_state  out  4  expected state at the first error
- lost  out  1  high while resynchronising

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Reset values: `state`=FETCH, expected state=FETCH, `retire`=0, counters=0, `err`=0, `err_state`=0, `lost`=0.
  - Reset asserted mid-instruction discards the partial instruction; no `retire`.
- Monitor keeps a registered expected state `exp`. Each cycle it compares the live vector against the signature of `exp`. All outputs are registered, one cycle latency.
- Signatures (fields not listed = 0; `alusrcb` and `pcsrc` = 00 unless given):
  - FETCH: pcen, irwrite, alusrcb=01
  - DECODE: alusrcb=11
  - MEMADR and ADDIEX: alusrca, alusrcb=10
  - MEMRD: iord
  - MEMWB: regwrite, memtoreg
  - MEMWR: iord, memwrite
  - RTYPEEX: alusrca
  - RTYPEWB: regwrite, regdst
  - BEQEX: alusrca, pcsrc=01, pcen=`zero`
  - ADDIWB: regwrite
  - JEX: pcen, pcsrc=10
- Successor rules:
  - FETCH → DECODE.
  - DECODE latches `op` into op_q, then branches on `op`: 100011/101011 → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX.
  - MEMADR → MEMRD (op_q=lw) or MEMWR (op_q=sw); MEMRD → MEMWB.
  - RTYPEEX → RTYPEWB; ADDIEX → ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
- MEMADR and ADDIEX share a signature. They are disambiguated only by op_q.
- `retire`=1 in the cycle after a matching terminal state. `instr_count` increments with it.
- `cycle_count` increments every non-reset cycle.
- Mismatch, or an unknown op at DECODE:
  - On the first error only, `err`←1 and `err_state`←`exp`.
  - `lost`←1 and `exp` is abandoned.
- While `lost`: each FETCH-signature cycle clears `lost` and sets `exp`=DECODE. No retire is counted for the aborted instruction.
- Once set, `err` clears only on reset.

Optional Feature:
- Macro: ALU_CHECK_EN.
- Defined: `alucontrol` is also part of the signature.
  - FETCH, DECODE, MEMADR, ADDIEX require 010; BEQEX requires 110.
  - RTYPEEX requires the value for `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other `funct` in RTYPEEX is an error.
- Undefined: `alucontrol` and `funct` are ignored. Ports remain present.

Decomposition:
- Package `ctrl_pkg`: 4-bit state enum FETCH=0 … JEX=11, opcode constants, funct constants, ALU control constants. Shared with `controller`.
- One sub-module `ctrl_sig_match`: combinational; given `exp`, op_q, `zero` and the vector, returns match. Keeps the successor FSM and counters in the parent.

Test Plan:
- Reset, then add sequence FETCH, DECODE(op=000000), RTYPEEX, RTYPEWB → `retire` pulse after RTYPEWB, `instr_count`=1, `cycle_count`=4, `err`=0.
- lw then sw back to back (5+4 cycles) → `instr_count`=2, `state` traces 0,1,2,3,4,0,1,2,5.
- beq with `zero`=1 (pcen=1 in BEQEX) then `zero`=0 (pcen=0) → both retire, no error. Forcing pcen=1 with `zero`=0 → `err`=1, `err_state`=8.
- addi: MEMADR-signature vector after DECODE with op=001000 → decoded as ADDIEX (9) then ADDIWB (10), retire; same vector with op=100011 decodes as MEMADR (2).
- Inject memwrite=1 during RTYPEWB → `err`=1, `err_state`=7, `lost`=1; next FETCH vector clears `lost`; following j (op=000010) retires; `err` stays 1.
- ALU_CHECK_EN, sub (funct=100010) with `alucontrol`=010 in RTYPEEX → `err`=1, `err_state`=6. Same stimulus without the macro → no error. Reset asserted in RTYPEEX → no retire, counters 0.
